// File: rtl/rv32i_hazard_forward_unit_if.sv
// Decode-side view of the RV32i data-hazard unit: decode fields and redirect in,
// stall/forward selects and performance counters out.
interface rv32i_hazard_forward_unit_if #(
   parameter int N_STAGES   = 3,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
);
   localparam int SEL_W = $clog2(N_STAGES + 1);

   logic                  dec_valid_i;
   logic [REG_ADDR_W-1:0] dec_rs1_i;
   logic [REG_ADDR_W-1:0] dec_rs2_i;
   logic                  dec_rs1_used_i;
   logic                  dec_rs2_used_i;
   logic [REG_ADDR_W-1:0] dec_rd_i;
   logic                  dec_rd_we_i;
   logic                  dec_is_load_i;
   logic                  flush_i;
   logic                  cnt_clr_i;
   logic                  stall_o;
   logic [SEL_W-1:0]      fwd_rs1_sel_o;
   logic [SEL_W-1:0]      fwd_rs2_sel_o;
   logic [CNT_W-1:0]      stall_cnt_o;
   logic [CNT_W-1:0]      flush_cnt_o;

   modport master (
      output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs1_used_i, dec_rs2_used_i,
             dec_rd_i, dec_rd_we_i, dec_is_load_i, flush_i, cnt_clr_i,
      input  stall_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs1_used_i, dec_rs2_used_i,
             dec_rd_i, dec_rd_we_i, dec_is_load_i, flush_i, cnt_clr_i,
      output stall_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/rv32i_hazard_forward_unit.sv
// RV32i data-hazard unit: shadow scoreboard of in-flight destinations (EX..WB),
// forwarding-select / stall generation for the decode sources, and stall/flush counters.
module rv32i_hazard_forward_unit #(
   parameter int N_STAGES       = 3,
   parameter int REG_ADDR_W     = 5,
   parameter bit FWD_EN         = 1'b1,
   parameter int LOAD_FWD_STAGE = 2,
   parameter bit RF_BYPASS      = 1'b0,
   parameter int CNT_W          = 32
) (
   input  logic                      clk_i,
   input  logic                      resetn_i,
   rv32i_hazard_forward_unit_if.slave hz
);
   localparam int SEL_W = $clog2(N_STAGES + 1);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
      logic                  is_load;
   } sb_entry_t;

   sb_entry_t sb_q [1:N_STAGES];
   sb_entry_t sb_d [1:N_STAGES];

   logic [N_STAGES:1] match_rs1;
   logic [N_STAGES:1] match_rs2;
   logic [SEL_W-1:0]  win_rs1;
   logic [SEL_W-1:0]  win_rs2;
   logic              load_rs1;
   logic              load_rs2;
   logic              hazard_rs1;
   logic              hazard_rs2;
   logic              stall;
   logic              accept;

   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   // With a write-first register file the WB-stage value is already readable.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      match_rs1 = '0;
      match_rs2 = '0;
      for (int k = 1; k <= N_STAGES; k++) begin
         if (sb_q[k].valid && sb_q[k].we && (sb_q[k].rd != '0) &&
             !(RF_BYPASS && (k == N_STAGES))) begin
            match_rs1[k] = hz.dec_valid_i && hz.dec_rs1_used_i && (sb_q[k].rd == hz.dec_rs1_i);
            match_rs2[k] = hz.dec_valid_i && hz.dec_rs2_used_i && (sb_q[k].rd == hz.dec_rs2_i);
         end
      end
   end

   // Walk from the oldest stage to the youngest so the lowest matching k wins.
   always_comb begin
      win_rs1  = '0;
      win_rs2  = '0;
      load_rs1 = 1'b0;
      load_rs2 = 1'b0;
      for (int k = N_STAGES; k >= 1; k--) begin
         if (match_rs1[k]) begin
            win_rs1  = SEL_W'(k);
            load_rs1 = sb_q[k].is_load;
         end
         if (match_rs2[k]) begin
            win_rs2  = SEL_W'(k);
            load_rs2 = sb_q[k].is_load;
         end
      end
   end

   always_comb begin
      if (FWD_EN) begin
         hazard_rs1 = load_rs1 && (win_rs1 != '0) && (int'(win_rs1) < LOAD_FWD_STAGE);
         hazard_rs2 = load_rs2 && (win_rs2 != '0) && (int'(win_rs2) < LOAD_FWD_STAGE);
      end else begin
         hazard_rs1 = |match_rs1;
         hazard_rs2 = |match_rs2;
      end
   end

   // A redirect discards the decode instruction, so there is nothing left to stall.
   assign stall  = resetn_i && !hz.flush_i && (hazard_rs1 || hazard_rs2);
   assign accept = hz.dec_valid_i && !stall && !hz.flush_i;

   assign hz.stall_o       = stall;
   assign hz.fwd_rs1_sel_o = (FWD_EN && resetn_i) ? win_rs1 : '0;
   assign hz.fwd_rs2_sel_o = (FWD_EN && resetn_i) ? win_rs2 : '0;
   assign hz.stall_cnt_o   = stall_cnt_q;
   assign hz.flush_cnt_o   = flush_cnt_q;

   // Back-end stages never hold; a stalled or flushed decode slot becomes a bubble.
   always_comb begin
      sb_d[1] = '0;
      if (accept) begin
         sb_d[1].valid   = 1'b1;
         sb_d[1].rd      = hz.dec_rd_i;
         sb_d[1].we      = hz.dec_rd_we_i;
         sb_d[1].is_load = hz.dec_is_load_i;
      end
      for (int k = 2; k <= N_STAGES; k++) begin
         sb_d[k] = sb_q[k-1];
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         // NOTE: the scoreboard array is reset because its valid bits gate every hazard match.
         for (int k = 1; k <= N_STAGES; k++) begin
            sb_q[k] <= '0;
         end
      end else begin
         // NOTE: state registers use non-blocking assignments so all stages shift on the same edge.
         for (int k = 1; k <= N_STAGES; k++) begin
            sb_q[k] <= sb_d[k];
         end
      end
   end

   // Saturating counters; clear takes priority over increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hz.cnt_clr_i) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (hz.flush_i && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
endmodule

// File: tb/tb_rv32i_hazard_forward_unit.sv
// Bench for rv32i_hazard_forward_unit: three configurations (forwarding, stall-only,
// stall-only with write-first regfile) checked every cycle against a timestamp model.
module tb_rv32i_hazard_forward_unit;
   localparam int NST = 3;
   localparam int LFS = 2;

   logic clk;
   logic resetn;
   logic       dec_valid, dec_rs1_used, dec_rs2_used, dec_rd_we, dec_is_load, flush, cnt_clr;
   logic [4:0] dec_rs1, dec_rs2, dec_rd;

   rv32i_hazard_forward_unit_if #(.N_STAGES(NST), .REG_ADDR_W(5), .CNT_W(4))  hz0 ();
   rv32i_hazard_forward_unit_if #(.N_STAGES(NST), .REG_ADDR_W(5), .CNT_W(32)) hz1 ();
   rv32i_hazard_forward_unit_if #(.N_STAGES(NST), .REG_ADDR_W(5), .CNT_W(32)) hz2 ();

   rv32i_hazard_forward_unit #(.N_STAGES(NST), .REG_ADDR_W(5), .FWD_EN(1'b1),
      .LOAD_FWD_STAGE(LFS), .RF_BYPASS(1'b0), .CNT_W(4))
      u_fwd (.clk_i(clk), .resetn_i(resetn), .hz(hz0));
   rv32i_hazard_forward_unit #(.N_STAGES(NST), .REG_ADDR_W(5), .FWD_EN(1'b0),
      .LOAD_FWD_STAGE(LFS), .RF_BYPASS(1'b0), .CNT_W(32))
      u_stl (.clk_i(clk), .resetn_i(resetn), .hz(hz1));
   rv32i_hazard_forward_unit #(.N_STAGES(NST), .REG_ADDR_W(5), .FWD_EN(1'b0),
      .LOAD_FWD_STAGE(LFS), .RF_BYPASS(1'b1), .CNT_W(32))
      u_byp (.clk_i(clk), .resetn_i(resetn), .hz(hz2));

   assign hz0.dec_valid_i = dec_valid;        assign hz1.dec_valid_i = dec_valid;        assign hz2.dec_valid_i = dec_valid;
   assign hz0.dec_rs1_i = dec_rs1;            assign hz1.dec_rs1_i = dec_rs1;            assign hz2.dec_rs1_i = dec_rs1;
   assign hz0.dec_rs2_i = dec_rs2;            assign hz1.dec_rs2_i = dec_rs2;            assign hz2.dec_rs2_i = dec_rs2;
   assign hz0.dec_rs1_used_i = dec_rs1_used;  assign hz1.dec_rs1_used_i = dec_rs1_used;  assign hz2.dec_rs1_used_i = dec_rs1_used;
   assign hz0.dec_rs2_used_i = dec_rs2_used;  assign hz1.dec_rs2_used_i = dec_rs2_used;  assign hz2.dec_rs2_used_i = dec_rs2_used;
   assign hz0.dec_rd_i = dec_rd;              assign hz1.dec_rd_i = dec_rd;              assign hz2.dec_rd_i = dec_rd;
   assign hz0.dec_rd_we_i = dec_rd_we;        assign hz1.dec_rd_we_i = dec_rd_we;        assign hz2.dec_rd_we_i = dec_rd_we;
   assign hz0.dec_is_load_i = dec_is_load;    assign hz1.dec_is_load_i = dec_is_load;    assign hz2.dec_is_load_i = dec_is_load;
   assign hz0.flush_i = flush;                assign hz1.flush_i = flush;                assign hz2.flush_i = flush;
   assign hz0.cnt_clr_i = cnt_clr;            assign hz1.cnt_clr_i = cnt_clr;            assign hz2.cnt_clr_i = cnt_clr;

   logic        act_st [3];
   logic [1:0]  act_s1 [3];
   logic [1:0]  act_s2 [3];
   logic [63:0] act_sc [3];
   logic [63:0] act_fc [3];
   assign act_st[0] = hz0.stall_o;          assign act_st[1] = hz1.stall_o;          assign act_st[2] = hz2.stall_o;
   assign act_s1[0] = hz0.fwd_rs1_sel_o;    assign act_s1[1] = hz1.fwd_rs1_sel_o;    assign act_s1[2] = hz2.fwd_rs1_sel_o;
   assign act_s2[0] = hz0.fwd_rs2_sel_o;    assign act_s2[1] = hz1.fwd_rs2_sel_o;    assign act_s2[2] = hz2.fwd_rs2_sel_o;
   assign act_sc[0] = 64'(hz0.stall_cnt_o); assign act_sc[1] = 64'(hz1.stall_cnt_o); assign act_sc[2] = 64'(hz2.stall_cnt_o);
   assign act_fc[0] = 64'(hz0.flush_cnt_o); assign act_fc[1] = 64'(hz1.flush_cnt_o); assign act_fc[2] = 64'(hz2.flush_cnt_o);

   typedef struct {
      bit       valid;
      bit [4:0] rs1;
      bit       u1;
      bit [4:0] rs2;
      bit       u2;
      bit [4:0] rd;
      bit       we;
      bit       ld;
      bit       flush;
      bit       clr;
   } in_t;

   typedef struct {
      in_t      in;
      bit       e_st;
      bit [1:0] e_s1;
      bit [1:0] e_s2;
   } vec_t;

   // Model: each accepted instruction is remembered with the cycle it left decode;
   // its pipeline stage is simply (current cycle - accept cycle).
   typedef struct {
      int       cfg;
      bit [4:0] rd;
      bit       we;
      bit       ld;
      int       t;
   } inflight_t;

   inflight_t   hist [$];
   int          cyc;
   logic [63:0] cnt_st [3];
   logic [63:0] cnt_fl [3];
   int          n_vec;
   int          n_bad;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] cmax(input int c);
      return (c == 0) ? 64'd15 : 64'hFFFF_FFFF;
   endfunction

   function automatic void model_reset();
      hist.delete();
      cyc = 0;
      for (int c = 0; c < 3; c++) begin
         cnt_st[c] = '0;
         cnt_fl[c] = '0;
      end
   endfunction

   function automatic void model_eval(input int c, output bit st, output bit [1:0] s1, output bit [1:0] s2);
      int best1, best2, age;
      bit ld1, ld2, h1, h2;
      best1 = 0; best2 = 0; ld1 = 0; ld2 = 0;
      foreach (hist[i]) begin
         age = cyc - hist[i].t;
         if (hist[i].cfg != c || age < 1 || age > NST) continue;
         if (c == 2 && age == NST) continue;
         if (!hist[i].we || hist[i].rd == 0) continue;
         if (dec_valid && dec_rs1_used && hist[i].rd == dec_rs1 && (best1 == 0 || age < best1)) begin
            best1 = age; ld1 = hist[i].ld;
         end
         if (dec_valid && dec_rs2_used && hist[i].rd == dec_rs2 && (best2 == 0 || age < best2)) begin
            best2 = age; ld2 = hist[i].ld;
         end
      end
      if (c == 0) begin
         h1 = (best1 != 0) && ld1 && (best1 < LFS);
         h2 = (best2 != 0) && ld2 && (best2 < LFS);
         s1 = 2'(best1);
         s2 = 2'(best2);
      end else begin
         h1 = (best1 != 0);
         h2 = (best2 != 0);
         s1 = 2'd0;
         s2 = 2'd0;
      end
      st = (h1 || h2) && !flush && resetn;
      if (!resetn) begin
         s1 = 2'd0;
         s2 = 2'd0;
      end
   endfunction

   task automatic model_commit();
      bit st;
      bit [1:0] a, b;
      inflight_t e;
      for (int c = 0; c < 3; c++) begin
         model_eval(c, st, a, b);
         if (dec_valid && !st && !flush) begin
            e.cfg = c; e.rd = dec_rd; e.we = dec_rd_we; e.ld = dec_is_load; e.t = cyc;
            hist.push_back(e);
         end
         if (cnt_clr) begin
            cnt_st[c] = '0;
            cnt_fl[c] = '0;
         end else begin
            if (st && cnt_st[c] < cmax(c)) cnt_st[c] = cnt_st[c] + 1;
            if (flush && cnt_fl[c] < cmax(c)) cnt_fl[c] = cnt_fl[c] + 1;
         end
      end
      cyc++;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (cyc - hist[i].t > NST) hist.delete(i);
      end
   endtask

   task automatic model_check_all();
      bit st;
      bit [1:0] s1, s2;
      for (int c = 0; c < 3; c++) begin
         model_eval(c, st, s1, s2);
         check($sformatf("cfg%0d stall_o", c),       64'(act_st[c]), 64'(st));
         check($sformatf("cfg%0d fwd_rs1_sel_o", c), 64'(act_s1[c]), 64'(s1));
         check($sformatf("cfg%0d fwd_rs2_sel_o", c), 64'(act_s2[c]), 64'(s2));
         check($sformatf("cfg%0d stall_cnt_o", c),   act_sc[c], cnt_st[c]);
         check($sformatf("cfg%0d flush_cnt_o", c),   act_fc[c], cnt_fl[c]);
      end
   endtask

   function automatic in_t mk(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                              input int rd, input bit we, input bit ld, input bit fl, input bit clr);
      in_t r;
      r.valid = v; r.rs1 = 5'(rs1); r.u1 = u1; r.rs2 = 5'(rs2); r.u2 = u2;
      r.rd = 5'(rd); r.we = we; r.ld = ld; r.flush = fl; r.clr = clr;
      return r;
   endfunction

   function automatic vec_t row(input in_t i, input bit st, input int s1, input int s2);
      vec_t v;
      v.in = i; v.e_st = st; v.e_s1 = 2'(s1); v.e_s2 = 2'(s2);
      return v;
   endfunction

   task automatic drive(input in_t r);
      @(negedge clk);
      dec_valid = r.valid; dec_rs1 = r.rs1; dec_rs1_used = r.u1; dec_rs2 = r.rs2;
      dec_rs2_used = r.u2; dec_rd = r.rd; dec_rd_we = r.we; dec_is_load = r.ld;
      flush = r.flush; cnt_clr = r.clr;
      #1;
      model_check_all();
   endtask

   task automatic tick();
      @(posedge clk);
      if (resetn) model_commit();
   endtask

   task automatic set_idle();
      dec_valid = 0; dec_rs1 = 0; dec_rs1_used = 0; dec_rs2 = 0; dec_rs2_used = 0;
      dec_rd = 0; dec_rd_we = 0; dec_is_load = 0; flush = 0; cnt_clr = 0;
   endtask

   task automatic do_reset();
      set_idle();
      resetn = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      tick();
   endtask

   vec_t vecs [13];
   in_t  idle_i, lw5, use5, addi5, add5, r;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      clk = 1'b0;
      resetn = 1'b1;
      n_vec = 0;
      n_bad = 0;
      set_idle();
      model_reset();
      idle_i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      lw5    = mk(1, 2, 1, 0, 0, 5, 1, 1, 0, 0);
      use5   = mk(1, 5, 1, 3, 1, 10, 1, 0, 0, 0);
      addi5  = mk(1, 1, 1, 0, 0, 5, 1, 0, 0, 0);
      add5   = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);

      //                 v rs1 u1 rs2 u2 rd we ld fl clr     st s1 s2
      vecs[0]  = row(mk(1,  1, 1,  0, 0,  5, 1, 0, 0, 0),  0, 0, 0); // addi x5,x1
      vecs[1]  = row(mk(1,  5, 1,  1, 1,  6, 1, 0, 0, 0),  0, 1, 0); // add x6,x5,x1
      vecs[2]  = row(mk(1,  2, 1,  0, 0,  0, 1, 0, 0, 0),  0, 0, 0); // addi x0,x2
      vecs[3]  = row(mk(1,  0, 1,  0, 1,  8, 1, 0, 0, 0),  0, 0, 0); // add x8,x0,x0
      vecs[4]  = row(mk(1,  1, 1,  0, 0,  7, 1, 0, 0, 0),  0, 0, 0); // addi x7,x1
      vecs[5]  = row(mk(1,  1, 1,  0, 0,  7, 1, 0, 0, 0),  0, 0, 0); // addi x7,x1
      vecs[6]  = row(mk(1,  7, 1,  7, 1,  9, 1, 0, 0, 0),  0, 1, 1); // add x9,x7,x7
      vecs[7]  = row(mk(1,  2, 1,  0, 0,  5, 1, 1, 0, 0),  0, 0, 0); // lw x5
      vecs[8]  = row(mk(1,  5, 1,  3, 1, 10, 1, 0, 0, 0),  1, 1, 0); // load-use stall
      vecs[9]  = row(mk(1,  5, 1,  3, 1, 10, 1, 0, 0, 0),  0, 2, 0); // forwarded from MEM
      vecs[10] = row(mk(1,  2, 1,  0, 0, 11, 1, 1, 0, 0),  0, 0, 0); // lw x11
      vecs[11] = row(mk(1, 11, 1,  0, 0, 11, 1, 0, 1, 0),  0, 1, 0); // load-use + flush
      vecs[12] = row(mk(1, 11, 1,  0, 0, 12, 1, 0, 0, 0),  0, 2, 0); // flushed slot was a bubble

      #3 resetn = 1'b0;
      do_reset();

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].in);
         check($sformatf("vec%0d stall_o", i),       64'(act_st[0]), 64'(vecs[i].e_st));
         check($sformatf("vec%0d fwd_rs1_sel_o", i), 64'(act_s1[0]), 64'(vecs[i].e_s1));
         check($sformatf("vec%0d fwd_rs2_sel_o", i), 64'(act_s2[0]), 64'(vecs[i].e_s2));
         tick();
      end
      #1;
      check("fwd stall_cnt after load-use", act_sc[0], 64'd1);
      check("fwd flush_cnt after flush", act_fc[0], 64'd1);

      // Asynchronous reset while a load-use stall is being raised.
      drive(lw5);
      tick();
      drive(use5);
      check("pre-reset stall_o", 64'(act_st[0]), 64'd1);
      #2 resetn = 1'b0;
      model_reset();
      #1;
      check("reset stall_o immediate", 64'(act_st[0]), 64'd0);
      check("reset stall_cnt immediate", act_sc[0], 64'd0);
      check("reset flush_cnt immediate", act_fc[0], 64'd0);
      model_check_all();
      @(posedge clk);
      #1;
      model_check_all();
      @(negedge clk);
      set_idle();
      resetn = 1'b1;
      tick();

      // Stall-only configurations: RAW on an ALU result.
      drive(addi5);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(add5);
         check($sformatf("stall-only cycle%0d stall_o", i), 64'(act_st[1]), 64'(i < 3));
         check($sformatf("bypass cycle%0d stall_o", i),     64'(act_st[2]), 64'(i < 2));
         tick();
      end
      #1;
      check("stall-only stall_cnt", act_sc[1], 64'd3);
      check("bypass stall_cnt", act_sc[2], 64'd2);

      // 17 load-use stalls into a 4-bit counter.
      for (int i = 0; i < 17; i++) begin
         drive(lw5);  tick();
         drive(use5); tick();
         drive(use5); tick();
      end
      #1;
      check("fwd stall_cnt saturated", act_sc[0], 64'd15);
      drive(lw5);
      tick();
      r = use5;
      r.clr = 1'b1;
      drive(r);
      check("stall with clear stall_o", 64'(act_st[0]), 64'd1);
      tick();
      #1;
      check("fwd stall_cnt cleared", act_sc[0], 64'd0);
      check("fwd flush_cnt cleared", act_fc[0], 64'd0);

      // Random traffic on a small register set to provoke overlapping hazards.
      for (int i = 0; i < 600; i++) begin
         r = mk($urandom_range(0, 9) != 0,
                int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                int'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 199) == 0);
         drive(r);
         if (i % 150 == 75) begin
            #2 resetn = 1'b0;
            model_reset();
            #1;
            model_check_all();
            @(posedge clk);
            @(negedge clk);
            set_idle();
            resetn = 1'b1;
         end
         tick();
      end
      drive(idle_i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
